// File: rtl/xosera_bus_initiator.sv
// rtl/xosera_bus_initiator.sv - host-side master for the Xosera 8-bit register bus
// Splits 16-bit register requests into timed even/odd byte cycles with fully registered pins.
module xosera_bus_initiator #(
   parameter int SETUP_CLKS  = 1,
   parameter int STROBE_CLKS = 4,
   parameter int HOLD_CLKS   = 1
) (
   input  logic        clk,
   input  logic        reset_n_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_write_i,
   input  logic        req_word_i,
   input  logic        req_bytesel_i,
   input  logic [3:0]  req_reg_num_i,
   input  logic [15:0] req_data_i,
   output logic        rsp_valid_o,
   output logic [15:0] rsp_data_o,
   output logic        bus_cs_n_o,
   output logic        bus_rd_nwr_o,
   output logic        bus_bytesel_o,
   output logic [3:0]  bus_reg_num_o,
   output logic [7:0]  bus_data_o,
   output logic        bus_data_oe_o,
   input  logic [7:0]  bus_data_i
);

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

   localparam logic [3:0] SETUP_LD  = 4'(SETUP_CLKS - 1);
   localparam logic [3:0] STROBE_LD = 4'(STROBE_CLKS - 1);
   localparam logic [3:0] HOLD_LD   = 4'(HOLD_CLKS - 1);

   state_t      state, state_n;
   logic [3:0]  cnt, cnt_n;
   logic        wr_q, wr_n;
   logic        word_q, word_n;
   logic        pend_q, pend_n;
   logic [15:0] dat_q, dat_n;
   logic        cs_n_n, rd_nwr_n, bytesel_n, oe_n, rsp_valid_n;
   logic [3:0]  reg_num_n;
   logic [7:0]  dout_n;
   logic [15:0] rsp_data_n;

   assign req_ready_o = (state == IDLE);

   always_ff @(posedge clk or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state         <= IDLE;
         cnt           <= 4'd0;
         wr_q          <= 1'b0;
         word_q        <= 1'b0;
         pend_q        <= 1'b0;
         dat_q         <= 16'h0000;
         bus_cs_n_o    <= 1'b1;
         bus_rd_nwr_o  <= 1'b1;
         bus_bytesel_o <= 1'b0;
         bus_reg_num_o <= 4'd0;
         bus_data_o    <= 8'h00;
         bus_data_oe_o <= 1'b0;
         rsp_valid_o   <= 1'b0;
         rsp_data_o    <= 16'h0000;
      end else begin
         state         <= state_n;
         cnt           <= cnt_n;
         wr_q          <= wr_n;
         word_q        <= word_n;
         pend_q        <= pend_n;
         dat_q         <= dat_n;
         bus_cs_n_o    <= cs_n_n;
         bus_rd_nwr_o  <= rd_nwr_n;
         bus_bytesel_o <= bytesel_n;
         bus_reg_num_o <= reg_num_n;
         bus_data_o    <= dout_n;
         bus_data_oe_o <= oe_n;
         rsp_valid_o   <= rsp_valid_n;
         rsp_data_o    <= rsp_data_n;
      end
   end

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      wr_n        = wr_q;
      word_n      = word_q;
      pend_n      = pend_q;
      dat_n       = dat_q;
      cs_n_n      = bus_cs_n_o;
      rd_nwr_n    = bus_rd_nwr_o;
      bytesel_n   = bus_bytesel_o;
      reg_num_n   = bus_reg_num_o;
      dout_n      = bus_data_o;
      oe_n        = bus_data_oe_o;
      rsp_valid_n = 1'b0;
      rsp_data_n  = rsp_data_o;

      case (state)
         IDLE: begin
            if (req_valid_i) begin
               wr_n      = req_write_i;
               word_n    = req_word_i;
               pend_n    = req_word_i;
               dat_n     = req_data_i;
               bytesel_n = ~req_word_i & req_bytesel_i;
               dout_n    = bytesel_n ? req_data_i[7:0] : req_data_i[15:8];
               rd_nwr_n  = ~req_write_i;
               oe_n      = req_write_i;
               reg_num_n = req_reg_num_i;
               cs_n_n    = 1'b1;
               cnt_n     = SETUP_LD;
               state_n   = SETUP;
            end
         end
         SETUP: begin
            if (cnt == 4'd0) begin
               cs_n_n  = 1'b0;
               cnt_n   = STROBE_LD;
               state_n = STROBE;
            end else begin
               cnt_n = cnt - 4'd1;
            end
         end
         STROBE: begin
            if (cnt == 4'd0) begin
               cs_n_n  = 1'b1;
               cnt_n   = HOLD_LD;
               state_n = HOLD;
               // capture on the edge that raises cs_n; byte reads zero the unused lane
               if (!wr_q) begin
                  if (!word_q)
                     rsp_data_n = 16'h0000;
                  if (bus_bytesel_o)
                     rsp_data_n[7:0] = bus_data_i;
                  else
                     rsp_data_n[15:8] = bus_data_i;
               end
            end else begin
               cnt_n = cnt - 4'd1;
            end
         end
         HOLD: begin
            if (cnt == 4'd0) begin
               if (pend_q) begin
                  pend_n    = 1'b0;
                  bytesel_n = 1'b1;
                  dout_n    = dat_q[7:0];
                  cnt_n     = SETUP_LD;
                  state_n   = SETUP;
               end else begin
                  oe_n        = 1'b0;
                  rd_nwr_n    = 1'b1;
                  rsp_valid_n = 1'b1;
                  state_n     = IDLE;
               end
            end else begin
               cnt_n = cnt - 4'd1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_xosera_bus_initiator.sv
// tb/tb_xosera_bus_initiator.sv - directed bench for xosera_bus_initiator
// Instance a uses default timing, instance b uses SETUP=2 STROBE=1 HOLD=3.
module tb_xosera_bus_initiator;

   localparam int SA = 1, TA = 4, HA = 1;
   localparam int SB = 2, TB = 1, HB = 3;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic [1:0] valid = 2'b00;
   logic req_write = 1'b0, req_word = 1'b0, req_bytesel = 1'b0;
   logic [3:0] req_reg_num = 4'd0;
   logic [15:0] req_data = 16'h0000;
   logic [7:0] rd_even = 8'h00, rd_odd = 8'h00;

   logic [1:0] ready, rsp_valid, cs_n, rd_nwr, bytesel, oe;
   logic [1:0][15:0] rsp_data;
   logic [1:0][3:0] reg_num;
   logic [1:0][7:0] dout, din;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   assign din[0] = bytesel[0] ? rd_odd : rd_even;
   assign din[1] = bytesel[1] ? rd_odd : rd_even;

   xosera_bus_initiator #(.SETUP_CLKS(SA), .STROBE_CLKS(TA), .HOLD_CLKS(HA)) u_a (
      .clk(clk), .reset_n_i(reset_n),
      .req_valid_i(valid[0]), .req_ready_o(ready[0]),
      .req_write_i(req_write), .req_word_i(req_word), .req_bytesel_i(req_bytesel),
      .req_reg_num_i(req_reg_num), .req_data_i(req_data),
      .rsp_valid_o(rsp_valid[0]), .rsp_data_o(rsp_data[0]),
      .bus_cs_n_o(cs_n[0]), .bus_rd_nwr_o(rd_nwr[0]), .bus_bytesel_o(bytesel[0]),
      .bus_reg_num_o(reg_num[0]), .bus_data_o(dout[0]), .bus_data_oe_o(oe[0]),
      .bus_data_i(din[0])
   );

   xosera_bus_initiator #(.SETUP_CLKS(SB), .STROBE_CLKS(TB), .HOLD_CLKS(HB)) u_b (
      .clk(clk), .reset_n_i(reset_n),
      .req_valid_i(valid[1]), .req_ready_o(ready[1]),
      .req_write_i(req_write), .req_word_i(req_word), .req_bytesel_i(req_bytesel),
      .req_reg_num_i(req_reg_num), .req_data_i(req_data),
      .rsp_valid_o(rsp_valid[1]), .rsp_data_o(rsp_data[1]),
      .bus_cs_n_o(cs_n[1]), .bus_rd_nwr_o(rd_nwr[1]), .bus_bytesel_o(bytesel[1]),
      .bus_reg_num_o(reg_num[1]), .bus_data_o(dout[1]), .bus_data_oe_o(oe[1]),
      .bus_data_i(din[1])
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // expected {cs_n, rd_nwr, bytesel, oe, write byte} k clocks after the accept edge
   function automatic logic [11:0] exp_bus(input int k, input int s, input int t, input int h,
                                          input bit wr, input bit word, input bit bsel,
                                          input logic [15:0] d);
      int p, b;
      bit lane, cs;
      p = (k - 1) % (s + t + h);
      b = (k - 1) / (s + t + h);
      lane = word ? b[0] : bsel;
      cs = !(p >= s && p < s + t);
      return {cs, ~wr, lane, wr, wr ? (lane ? d[7:0] : d[15:8]) : 8'h00};
   endfunction

   function automatic logic [11:0] obs(input int i, input bit wr);
      return {cs_n[i], rd_nwr[i], bytesel[i], oe[i], wr ? dout[i] : 8'h00};
   endfunction

   logic [1:0] pv = 2'b00, pcs, prd, pbs;
   logic [1:0][3:0] prn;
   int run[2] = '{0, 0};

   task automatic inv(input int i);
      if (!reset_n) begin
         pv[i] = 1'b0;
         run[i] = 0;
      end else begin
         chk("oe_while_read", {31'd0, oe[i] & rd_nwr[i]}, 32'd0);
         if (pv[i] && {rd_nwr[i], bytesel[i], reg_num[i]} !== {prd[i], pbs[i], prn[i]})
            chk("addr_change_cs", {30'd0, pcs[i], cs_n[i]}, 32'd3);
         if (!cs_n[i]) begin
            run[i]++;
         end else begin
            if (pv[i] && !pcs[i])
               chk("strobe_len", run[i], (i == 1) ? TB : TA);
            run[i] = 0;
         end
         pcs[i] = cs_n[i];
         prd[i] = rd_nwr[i];
         pbs[i] = bytesel[i];
         prn[i] = reg_num[i];
         pv[i] = 1'b1;
      end
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) inv(i);
   end

   task automatic wait_accept(input int i);
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < 30; n++) begin
         @(negedge clk);
         if (ready[i]) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      chk("accept", {31'd0, ok}, 32'd1);
   endtask

   task automatic run_req(input int i, input bit wr, input bit word, input bit bsel,
                          input logic [3:0] rn, input logic [15:0] d,
                          output int lat, output int strobes);
      logic pc;
      int s, t, h;
      s = (i == 1) ? SB : SA;
      t = (i == 1) ? TB : TA;
      h = (i == 1) ? HB : HA;
      req_write = wr; req_word = word; req_bytesel = bsel; req_reg_num = rn; req_data = d;
      valid[i] = 1'b1;
      wait_accept(i);
      valid[i] = 1'b0;
      req_data = ~d;
      req_reg_num = ~rn;
      lat = 0;
      strobes = 0;
      pc = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (rsp_valid[i]) begin
            lat = k;
            break;
         end
         chk("trace", {20'd0, obs(i, wr)}, {20'd0, exp_bus(k, s, t, h, wr, word, bsel, d)});
         chk("reg_num", {28'd0, reg_num[i]}, {28'd0, rn});
         if (pc && !cs_n[i]) strobes++;
         pc = cs_n[i];
      end
      chk("idle_bus", {29'd0, cs_n[i], rd_nwr[i], oe[i]}, 32'd6);
   endtask

   initial begin
      int lat, st, lat2;
      bit seen;

      #12;
      chk("rst_ready", {31'd0, ready[0]}, 32'd1);
      chk("rst_pins", {20'd0, cs_n[0], rd_nwr[0], bytesel[0], oe[0], dout[0]}, {20'd0, 12'hC00});
      chk("rst_reg_num", {28'd0, reg_num[0]}, 32'd0);
      chk("rst_rsp", {15'd0, rsp_valid[0], rsp_data[0]}, 32'd0);
      chk("rst_pins_b", {10'd0, cs_n[1], rd_nwr[1], oe[1], rsp_valid[1], rsp_data[1]}, {10'd0, 4'hC, 16'h0});
      @(negedge clk); #2 reset_n = 1'b1;

      run_req(0, 1'b1, 1'b1, 1'b0, 4'd3, 16'hA55A, lat, st);
      chk("wr_word_lat", lat, 13);
      chk("wr_word_strobes", st, 2);

      rd_even = 8'h12; rd_odd = 8'h34;
      run_req(0, 1'b0, 1'b1, 1'b0, 4'd7, 16'h0000, lat, st);
      chk("rd_word_lat", lat, 13);
      chk("rd_word_data", {16'd0, rsp_data[0]}, 32'h1234);

      rd_even = 8'hFF; rd_odd = 8'hC3;
      run_req(0, 1'b0, 1'b0, 1'b1, 4'd2, 16'h0000, lat, st);
      chk("rd_byte_lat", lat, 7);
      chk("rd_byte_strobes", st, 1);
      chk("rd_byte_data", {16'd0, rsp_data[0]}, 32'h00C3);

      run_req(0, 1'b1, 1'b0, 1'b0, 4'hA, 16'h3CC3, lat, st);
      chk("wr_byte_lat", lat, 7);
      chk("wr_byte_keeps_rsp", {16'd0, rsp_data[0]}, 32'h00C3);

      // back-to-back: write word, read request queued behind it with valid held
      rd_even = 8'h77; rd_odd = 8'hEE;
      req_write = 1'b1; req_word = 1'b1; req_bytesel = 1'b0; req_reg_num = 4'd4; req_data = 16'h0FF0;
      valid[0] = 1'b1;
      wait_accept(0);
      req_write = 1'b0; req_word = 1'b0; req_bytesel = 1'b0; req_reg_num = 4'd9;
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (rsp_valid[0]) begin
            lat = k;
            break;
         end
      end
      chk("b2b_lat", lat, 13);
      chk("b2b_ready_in_rsp", {31'd0, ready[0]}, 32'd1);
      @(negedge clk);
      chk("b2b_read_setup", {24'd0, cs_n[0], rd_nwr[0], oe[0], bytesel[0], reg_num[0]}, 32'hC9);
      valid[0] = 1'b0;
      lat2 = 0;
      for (int k = 2; k <= 40; k++) begin
         @(negedge clk);
         if (rsp_valid[0]) begin
            lat2 = k;
            break;
         end
      end
      chk("b2b_read_lat", lat2, 7);
      chk("b2b_read_data", {16'd0, rsp_data[0]}, 32'h7700);

      // reset during the second strobe clock of a write
      req_write = 1'b1; req_word = 1'b1; req_reg_num = 4'd3; req_data = 16'hBEEF;
      valid[0] = 1'b1;
      wait_accept(0);
      valid[0] = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_mid_strobe", {31'd0, cs_n[0]}, 32'd0);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_async_cs_oe", {30'd0, cs_n[0], oe[0]}, 32'd2);
      @(negedge clk); #2 reset_n = 1'b1;
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (rsp_valid[0]) seen = 1'b1;
      end
      chk("rst_no_rsp", {31'd0, seen}, 32'd0);
      chk("rst_ready_after", {31'd0, ready[0]}, 32'd1);
      run_req(0, 1'b1, 1'b0, 1'b1, 4'd1, 16'h00AB, lat, st);
      chk("post_rst_lat", lat, 7);

      run_req(1, 1'b1, 1'b1, 1'b0, 4'd5, 16'h1E2D, lat, st);
      chk("b_word_lat", lat, 13);
      chk("b_word_strobes", st, 2);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
